stopwatch_core: RTL

- Consumes the divided clock produced by clk_div, with OUTPUT_FREQ set so clk_out runs at 1 Hz on hardware.
- Synchronises that clock into the system domain and turns each rising edge into a one-cycle tick.
- Runs an mm:ss BCD stopwatch from those ticks, under start/stop and clear control, for the 7-segment display stage.

---
 rtl/stopwatch_pkg.sv | 52 +++++
 rtl/sync_edge_det.sv | 54 +++++
 rtl/stopwatch_core.sv | 128 ++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the mm:ss BCD stopwatch.
// Holds the FSM state encoding, the BCD time record and the one-second
// BCD increment used by stopwatch_core.
package stopwatch_pkg;

  localparam int BCD_W        = 4;
  localparam int SEC_TENS_MAX = 5;
  localparam int DIGIT_MAX    = 9;

  localparam logic [BCD_W-1:0] BCD_ONE        = BCD_W'(1);
  localparam logic [BCD_W-1:0] BCD_DIGIT_LAST = BCD_W'(DIGIT_MAX);
  localparam logic [BCD_W-1:0] BCD_TENS_LAST  = BCD_W'(SEC_TENS_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_t;

  typedef struct packed {
    logic [BCD_W-1:0] min_tens;
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_ones;
  } bcd_time_t;

  // Advance a BCD time by one second. Minutes roll 99 -> 00 here; the
  // configurable MAX_MIN wrap is handled by the caller.
  function automatic bcd_time_t bcd_next(input bcd_time_t t);
    bcd_time_t n;
    n = t;
    if (t.sec_ones != BCD_DIGIT_LAST) begin
      n.sec_ones = t.sec_ones + BCD_ONE;
    end else begin
      n.sec_ones = '0;
      if (t.sec_tens != BCD_TENS_LAST) begin
        n.sec_tens = t.sec_tens + BCD_ONE;
      end else begin
        n.sec_tens = '0;
        if (t.min_ones != BCD_DIGIT_LAST) begin
          n.min_ones = t.min_ones + BCD_ONE;
        end else begin
          n.min_ones = '0;
          n.min_tens = (t.min_tens != BCD_DIGIT_LAST) ? t.min_tens + BCD_ONE : '0;
        end
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
`timescale 1ns/1ps
// Multi-flop synchroniser followed by a rising-edge detector.
// Produces a registered one-cycle pulse SYNC_STAGES+1 cycles after a rise
// on async_in. A level that is already high when reset releases is not
// reported as an edge: a pulse needs a genuine low-to-high transition
// observed after reset.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_a_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  // valid_reg[i] is set once stage i (and the edge register for the top
  // bit) holds a real sample rather than its reset value.
  logic [SYNC_STAGES:0]   valid_reg;
  logic                   edge_reg;
  logic                   pulse_reg;
  logic                   sync_out;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = async_in;
      end else begin : g_chain
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  assign sync_out   = sync_reg[SYNC_STAGES-1];
  assign rise_pulse = pulse_reg;

  // Shift the async input through the chain and detect a qualified rise.
  always_ff @(posedge clk_in or negedge rst_a_n) begin
    if (!rst_a_n) begin
      sync_reg  <= '0;
      valid_reg <= '0;
      edge_reg  <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      sync_reg  <= sync_next;
      valid_reg <= {valid_reg[SYNC_STAGES-1:0], 1'b1};
      edge_reg  <= sync_out;
      pulse_reg <= sync_out & ~edge_reg & valid_reg[SYNC_STAGES];
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
`timescale 1ns/1ps
// mm:ss BCD stopwatch driven by a slow (1 Hz) clock from clk_div.
// The slow clock is synchronised into clk_in and each rise becomes a
// one-cycle tick; an IDLE/RUN/PAUSE FSM decides whether ticks are counted.
// Optional build macro: STOPWATCH_LAP_HOLD_EN adds a lap input that
// freezes the displayed value while counting continues internally.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_MIN     = 59
) (
  input  logic             clk_in,
  input  logic             rst_a_n,
  input  logic             slow_clk_in,
  input  logic             start_stop,
  input  logic             clear,
`ifdef STOPWATCH_LAP_HOLD_EN
  input  logic             lap,
`endif
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] min_tens,
  output logic             running,
  output logic             tick,
  output logic             wrap
);

  localparam logic [BCD_W-1:0] MAX_MIN_TENS = BCD_W'(MAX_MIN / 10);
  localparam logic [BCD_W-1:0] MAX_MIN_ONES = BCD_W'(MAX_MIN % 10);
  // Last value before the count rolls back to 00:00.
  localparam bcd_time_t LAST_TIME = {MAX_MIN_TENS, MAX_MIN_ONES, BCD_TENS_LAST, BCD_DIGIT_LAST};

  sw_state_t state_reg;
  bcd_time_t count_reg;
  bcd_time_t display;
  logic      running_reg;
  logic      wrap_reg;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clk_in    (clk_in),
    .rst_a_n   (rst_a_n),
    .async_in  (slow_clk_in),
    .rise_pulse(tick)
  );

  // Run/pause FSM plus the live count; clear overrides everything, and a
  // tick is counted only when the state at that edge is already RUN.
  always_ff @(posedge clk_in or negedge rst_a_n) begin
    if (!rst_a_n) begin
      state_reg   <= ST_IDLE;
      running_reg <= 1'b0;
      count_reg   <= '0;
      wrap_reg    <= 1'b0;
    end else begin
      wrap_reg <= 1'b0;
      if (clear) begin
        state_reg   <= ST_IDLE;
        running_reg <= 1'b0;
        count_reg   <= '0;
      end else begin
        if (state_reg == ST_RUN && tick) begin
          if (count_reg == LAST_TIME) begin
            count_reg <= '0;
            wrap_reg  <= 1'b1;
          end else begin
            count_reg <= bcd_next(count_reg);
          end
        end
        case (state_reg)
          ST_IDLE, ST_PAUSE: begin
            if (start_stop) begin
              state_reg   <= ST_RUN;
              running_reg <= 1'b1;
            end
          end
          ST_RUN: begin
            if (start_stop) begin
              state_reg   <= ST_PAUSE;
              running_reg <= 1'b0;
            end
          end
          default: begin
            state_reg   <= ST_IDLE;
            running_reg <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  logic      hold_reg;
  bcd_time_t lap_reg;

  // Lap capture: first lap in RUN freezes the display, next lap releases it.
  always_ff @(posedge clk_in or negedge rst_a_n) begin
    if (!rst_a_n) begin
      hold_reg <= 1'b0;
      lap_reg  <= '0;
    end else if (clear) begin
      hold_reg <= 1'b0;
    end else if (lap) begin
      if (hold_reg) begin
        hold_reg <= 1'b0;
      end else if (state_reg == ST_RUN) begin
        hold_reg <= 1'b1;
        lap_reg  <= count_reg;
      end
    end
  end

  assign display = hold_reg ? lap_reg : count_reg;
`else
  assign display = count_reg;
`endif

  assign sec_ones = display.sec_ones;
  assign sec_tens = display.sec_tens;
  assign min_ones = display.min_ones;
  assign min_tens = display.min_tens;
  assign running  = running_reg;
  assign wrap     = wrap_reg;

endmodule
